// File: rtl/fast_adder_pkg.sv
// Shared widths and the stage-register layout for the 4-stage pipelined adder.
package fast_adder_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned SLICE_W    = 8;
    localparam int unsigned NUM_STAGES = 4;
    localparam int unsigned HI_W       = DATA_W - SLICE_W;

    // sum accumulates finished bytes from bit 0 up; a_hi/b_hi hold the not-yet-added
    // operand bits right-justified, so the next slice always reads bits [7:0].
    typedef struct packed {
        logic [HI_W-1:0] sum;
        logic            carry;
        logic [HI_W-1:0] a_hi;
        logic [HI_W-1:0] b_hi;
    } stage_t;

endpackage

// File: rtl/cla8.sv
// 8-bit carry-lookahead adder: two 4-bit lookahead groups joined by group generate/propagate.
module cla8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    logic [7:0] g;
    logic [7:0] p;
    logic [7:0] c;
    logic [1:0] gg;
    logic [1:0] gp;
    logic [1:0] cg;

    always_comb begin
        g = a & b;
        p = a ^ b;
        gg = '0;
        gp = '0;
        c  = '0;
        for (int j = 0; j < 2; j++) begin
            gg[j] = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                  | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
            gp[j] = p[4*j+3] & p[4*j+2] & p[4*j+1] & p[4*j];
        end
        // Group carry-ins resolved in parallel from the group terms and cin.
        cg[0] = cin;
        cg[1] = gg[0] | (gp[0] & cin);
        cout  = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
        for (int j = 0; j < 2; j++) begin
            c[4*j]   = cg[j];
            c[4*j+1] = g[4*j] | (p[4*j] & cg[j]);
            c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & cg[j]);
            c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (p[4*j+2] & p[4*j+1] & g[4*j])
                     | (p[4*j+2] & p[4*j+1] & p[4*j] & cg[j]);
        end
        sum = p ^ c;
    end

endmodule

// File: rtl/fast_adder_4stage.sv
// Four-stage pipelined 32-bit unsigned adder; one 8-bit CLA slice per stage, 33-bit result.
module fast_adder_4stage
    import fast_adder_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic [DATA_W:0]   out_sum
);

    localparam int unsigned NUM_REGS = NUM_STAGES - 1;

    stage_t             st_q [NUM_REGS];
    stage_t             st_d [NUM_REGS];
    logic [DATA_W:0]    sum_q;
    logic [DATA_W:0]    sum_d;

    logic [SLICE_W-1:0] slice_a   [NUM_STAGES];
    logic [SLICE_W-1:0] slice_b   [NUM_STAGES];
    logic [SLICE_W-1:0] slice_sum [NUM_STAGES];
    logic               slice_cin [NUM_STAGES];
    logic               slice_cout[NUM_STAGES];

    always_comb begin
        slice_a[0]   = in_a[SLICE_W-1:0];
        slice_b[0]   = in_b[SLICE_W-1:0];
        slice_cin[0] = 1'b0;
        for (int k = 1; k < NUM_STAGES; k++) begin
            slice_a[k]   = st_q[k-1].a_hi[SLICE_W-1:0];
            slice_b[k]   = st_q[k-1].b_hi[SLICE_W-1:0];
            slice_cin[k] = st_q[k-1].carry;
        end
    end

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_slice
        cla8 u_cla8 (
            .a    (slice_a[k]),
            .b    (slice_b[k]),
            .cin  (slice_cin[k]),
            .sum  (slice_sum[k]),
            .cout (slice_cout[k])
        );
    end

    always_comb begin
        st_d[0].sum   = {{(HI_W-SLICE_W){1'b0}}, slice_sum[0]};
        st_d[0].carry = slice_cout[0];
        st_d[0].a_hi  = in_a[DATA_W-1:SLICE_W];
        st_d[0].b_hi  = in_b[DATA_W-1:SLICE_W];
        for (int k = 1; k < NUM_REGS; k++) begin
            st_d[k].sum                       = st_q[k-1].sum;
            st_d[k].sum[k*SLICE_W +: SLICE_W] = slice_sum[k];
            st_d[k].carry                     = slice_cout[k];
            st_d[k].a_hi = {{SLICE_W{1'b0}}, st_q[k-1].a_hi[HI_W-1:SLICE_W]};
            st_d[k].b_hi = {{SLICE_W{1'b0}}, st_q[k-1].b_hi[HI_W-1:SLICE_W]};
        end
        sum_d = {slice_cout[NUM_STAGES-1], slice_sum[NUM_STAGES-1], st_q[NUM_REGS-1].sum};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                st_q[k] <= '0;
            end
            sum_q <= '0;
        end else begin
            for (int k = 0; k < NUM_REGS; k++) begin
                st_q[k] <= st_d[k];
            end
            sum_q <= sum_d;
        end
    end

    assign out_sum = sum_q;

    // Last stage register only feeds its low byte into the final slice.
    logic unused_last_hi;
    assign unused_last_hi = ^{st_q[NUM_REGS-1].a_hi[HI_W-1:SLICE_W],
                              st_q[NUM_REGS-1].b_hi[HI_W-1:SLICE_W]};

endmodule

// File: tb/tb_fast_adder_4stage.sv
// Self-checking bench for fast_adder_4stage: vector table, random stream, reset and hold cases.
module tb_fast_adder_4stage;

    logic        clock;
    logic        reset;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [32:0] out_sum;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [32:0] exp;
        string       name;
    } vec_t;

    typedef struct {
        logic [32:0] exp;
        string       name;
    } sb_t;

    sb_t  sb_q[$];
    vec_t vecs[14];

    fast_adder_4stage dut (
        .clock   (clock),
        .reset   (reset),
        .in_a    (in_a),
        .in_b    (in_b),
        .out_sum (out_sum)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // One clock: drive a pair, queue its expected sum, compare whatever is due at the output.
    task automatic step(input logic [31:0] a, input logic [31:0] b, input logic [32:0] exp,
                        input string name);
        sb_t e;
        @(negedge clock);
        reset = 1'b0;
        in_a  = a;
        in_b  = b;
        e.exp  = exp;
        e.name = name;
        sb_q.push_back(e);
        @(posedge clock);
        #1;
        if (sb_q.size() == 4) begin
            e = sb_q.pop_front();
            check(e.name, out_sum, e.exp);
        end else begin
            check("fill_zero", out_sum, 33'h0);
        end
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            reset = 1'b1;
            in_a  = $urandom;
            in_b  = $urandom;
            @(posedge clock);
            #1;
            check("reset", out_sum, 33'h0);
        end
        sb_q.delete();
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;

        reset = 1'b1;
        in_a  = '0;
        in_b  = '0;

        vecs[0]  = '{32'd3827,       32'd9273,       33'd13100,         "basic_3827"};
        vecs[1]  = '{32'd0,          32'd9253,       33'd9253,          "basic_0_9253"};
        vecs[2]  = '{32'd1,          32'd0,          33'd1,             "basic_1_0"};
        vecs[3]  = '{32'd200,        32'd100,        33'd300,           "basic_200"};
        vecs[4]  = '{32'd13442,      32'd10042,      33'd23484,         "basic_13442"};
        vecs[5]  = '{32'd0,          32'd0,          33'd0,             "basic_zero"};
        vecs[6]  = '{32'h0FFF_FFFF,  32'hFFFF_FFEF,  33'h1_0FFF_FFEE,   "carry_a"};
        vecs[7]  = '{32'hFFFF_FFF1,  32'h0FFF_FFEF,  33'h1_0FFF_FFE0,   "carry_b"};
        vecs[8]  = '{32'hFFFF_0000,  32'hFFFF_0000,  33'h1_FFFE_0000,   "carry_c"};
        vecs[9]  = '{32'hFFFF_EEEE,  32'hFFFF_1111,  33'h1_FFFE_FFFF,   "carry_d"};
        vecs[10] = '{32'hFFFF_3841,  32'hFFFF_B3AE,  33'h1_FFFE_EBEF,   "carry_e"};
        vecs[11] = '{32'hFFFF_FFFF,  32'h0000_0001,  33'h1_0000_0000,   "ripple_all"};
        vecs[12] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  33'h1_FFFF_FFFE,   "max_ops"};
        vecs[13] = '{32'hEFFF_0001,  32'h0FFF_0000,  33'h0_FFFE_0001,   "no_cout"};

        do_reset(2);

        for (int i = 0; i < 14; i++) begin
            step(vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].name);
        end

        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rb = $urandom;
            step(ra, rb, {1'b0, ra} + {1'b0, rb}, "stream");
        end

        // Three results in flight when reset hits; none may surface afterward.
        step(32'd11, 32'd22, 33'd33, "pre_rst");
        step(32'd44, 32'd55, 33'd99, "pre_rst");
        step(32'h8000_0000, 32'h8000_0000, 33'h1_0000_0000, "pre_rst");
        do_reset(1);
        step(32'h1234_5678, 32'h1111_1111, 33'h0_2345_6789, "post_rst");
        for (int i = 0; i < 3; i++) begin
            step(32'd0, 32'd0, 33'd0, "drain");
        end

        do_reset(1);
        for (int i = 0; i < 10; i++) begin
            step(32'd3827, 32'd9273, 33'd13100, "held");
            if (i >= 3) begin
                #3;
                check("held_mid", out_sum, 33'd13100);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
